// File: rtl/scan_select_mux_if.sv
// rtl/scan_select_mux_if.sv - channel-select bus between the driving logic and scan_select_mux
//
// Purpose: groups the scan selector control inputs, channel data and registered outputs.
// Ports (master drives / slave receives):
//   en        advance strobe for scan modes
//   mode      00 manual, 01 scan up, 10 scan down, 11 freeze
//   sel_in    manual channel select
//   data_in   packed channel data, channel i = data_in[i*W +: W]
//   sel_q     registered channel index          (slave output)
//   onehot_q  registered one-hot of sel_q       (slave output)
//   data_out  registered selected channel data  (slave output)
//   sel_err   registered manual out-of-range    (slave output)
//   wrap      one-cycle scan wrap pulse         (slave output)
interface scan_select_mux_if #(
    parameter int N_CH = 8,
    parameter int W    = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic              en;
    logic [1:0]        mode;
    logic [SEL_W-1:0]  sel_in;
    logic [N_CH*W-1:0] data_in;
    logic [SEL_W-1:0]  sel_q;
    logic [N_CH-1:0]   onehot_q;
    logic [W-1:0]      data_out;
    logic              sel_err;
    logic              wrap;

    modport master (
        output en, mode, sel_in, data_in,
        input  sel_q, onehot_q, data_out, sel_err, wrap
    );

    modport slave (
        input  en, mode, sel_in, data_in,
        output sel_q, onehot_q, data_out, sel_err, wrap
    );
endinterface

// File: rtl/scan_select_mux.sv
// rtl/scan_select_mux.sv - N-channel registered selector with auto-scan, freeze and range check
//
// Purpose: binary select -> one-hot decode -> AND-OR mux, all outputs registered.
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   bus     scan_select_mux_if.slave (en, mode, sel_in, data_in in; sel_q, onehot_q,
//           data_out, sel_err, wrap out)
module scan_select_mux #(
    parameter int N_CH  = 8,
    parameter int W     = 4,
    parameter int DWELL = 4
) (
    input  logic clock,
    input  logic reset,
    scan_select_mux_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(N_CH - 1);
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        MANUAL  = 2'b00,
        SCAN_UP = 2'b01,
        SCAN_DN = 2'b10,
        FREEZE  = 2'b11
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [SEL_W-1:0]  sel_q;
    logic [N_CH-1:0]   onehot_q;
    logic [W-1:0]      data_out;
    logic              sel_err;
    logic              wrap;
    logic [DW_W-1:0]   dwell;

    logic              changed;
    logic              sel_valid;
    logic [DW_W-1:0]   dwell_base;
    logic              step;
    logic [SEL_W-1:0]  sel_next;
    logic [N_CH-1:0]   oh_next;
    logic [W-1:0]      mux_next;
    logic [N_CH-1:0]   oh_held;
    logic [W-1:0]      mux_held;

    // The state for this cycle's action is the decoded mode itself, so a mode
    // change takes effect on the same edge it is sampled.
    always_comb begin
        nxt        = state_t'(bus.mode);
        changed    = (nxt != state);
        sel_valid  = (bus.sel_in <= LAST);
        // A state change restarts dwell counting from zero.
        dwell_base = changed ? '0 : dwell;
        step       = bus.en && (dwell_base == DW_LAST);
    end

    always_comb begin
        sel_next = sel_q;
        case (nxt)
            MANUAL:  if (sel_valid) sel_next = bus.sel_in;
            SCAN_UP: if (step) sel_next = (sel_q == LAST) ? '0 : sel_q + SEL_W'(1);
            SCAN_DN: if (step) sel_next = (sel_q == '0) ? LAST : sel_q - SEL_W'(1);
            default: sel_next = sel_q;
        endcase
    end

    // One-hot decode and AND-OR mux. An invalid manual select decodes to all
    // zeros, which makes the mux output zero without any special case.
    always_comb begin
        oh_next  = '0;
        oh_held  = '0;
        mux_next = '0;
        mux_held = '0;
        for (int i = 0; i < N_CH; i++) begin
            oh_next[i] = (sel_next == SEL_W'(i)) && !((nxt == MANUAL) && !sel_valid);
            oh_held[i] = (sel_q == SEL_W'(i));
        end
        for (int i = 0; i < N_CH; i++) begin
            mux_next = mux_next | (bus.data_in[i*W +: W] & {W{oh_next[i]}});
            mux_held = mux_held | (bus.data_in[i*W +: W] & {W{oh_held[i]}});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= MANUAL;
            sel_q    <= '0;
            onehot_q <= N_CH'(1);
            data_out <= '0;
            sel_err  <= 1'b0;
            wrap     <= 1'b0;
            dwell    <= '0;
        end else begin
            state <= nxt;
            sel_q <= sel_next;
            wrap  <= 1'b0;
            case (nxt)
                MANUAL: begin
                    onehot_q <= oh_next;
                    data_out <= mux_next;
                    sel_err  <= !sel_valid;
                    dwell    <= '0;
                end
                SCAN_UP, SCAN_DN: begin
                    onehot_q <= oh_next;
                    data_out <= mux_next;
                    sel_err  <= 1'b0;
                    if (bus.en) dwell <= step ? '0 : dwell_base + DW_W'(1);
                    else        dwell <= dwell_base;
                    if (step) begin
                        wrap <= (nxt == SCAN_UP) ? (sel_q == LAST) : (sel_q == '0);
                    end
                end
                default: begin
                    // Freezing straight out of an errored manual select still
                    // rebuilds the outputs from the held channel.
                    if (changed && sel_err) begin
                        onehot_q <= oh_held;
                        data_out <= mux_held;
                        sel_err  <= 1'b0;
                    end
                    dwell <= dwell_base;
                end
            endcase
        end
    end

    assign bus.sel_q    = sel_q;
    assign bus.onehot_q = onehot_q;
    assign bus.data_out = data_out;
    assign bus.sel_err  = sel_err;
    assign bus.wrap     = wrap;
endmodule

// File: tb/tb_scan_select_mux.sv
// tb/tb_scan_select_mux.sv - directed self-checking bench for scan_select_mux
module tb_scan_select_mux;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    scan_select_mux_if #(.N_CH(8), .W(4)) if8 ();
    scan_select_mux_if #(.N_CH(6), .W(4)) if6 ();

    scan_select_mux #(.N_CH(8), .W(4), .DWELL(4)) u8 (.clock(clock), .reset(reset), .bus(if8.slave));
    scan_select_mux #(.N_CH(6), .W(4), .DWELL(1)) u6 (.clock(clock), .reset(reset), .bus(if6.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        if8.en      = 1'b0;
        if8.mode    = 2'b00;
        if8.sel_in  = 3'd0;
        if8.data_in = {4'hE, 4'hC, 4'hA, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        if6.en      = 1'b0;
        if6.mode    = 2'b00;
        if6.sel_in  = 3'd0;
        if6.data_in = {4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        tick();
        check("rst_sel",    if8.sel_q,    0);
        check("rst_onehot", if8.onehot_q, 32'h01);
        check("rst_data",   if8.data_out, 0);
        check("rst_err",    if8.sel_err,  0);
        check("rst_wrap",   if8.wrap,     0);
        check("rst6_onehot", if6.onehot_q, 32'h01);

        // manual select, valid
        reset = 1'b0;
        if8.sel_in = 3'd5;
        if6.sel_in = 3'd2;
        tick();
        check("man_sel",    if8.sel_q,    5);
        check("man_onehot", if8.onehot_q, 32'h20);
        check("man_data",   if8.data_out, 4'hA);
        check("man_err",    if8.sel_err,  0);
        check("man6_sel",   if6.sel_q,    2);
        check("man6_data",  if6.data_out, 4'h7);

        // out-of-range manual select on the 6-channel instance
        if6.sel_in = 3'd7;
        tick();
        check("oor_err",    if6.sel_err,  1);
        check("oor_onehot", if6.onehot_q, 0);
        check("oor_data",   if6.data_out, 0);
        check("oor_sel",    if6.sel_q,    2);
        if6.sel_in = 3'd6;
        tick();
        check("oor6_err",   if6.sel_err,  1);
        check("oor6_sel",   if6.sel_q,    2);
        if6.sel_in = 3'd5;
        tick();
        check("last_sel",    if6.sel_q,    5);
        check("last_onehot", if6.onehot_q, 32'h20);
        check("last_data",   if6.data_out, 4'h3);
        check("last_err",    if6.sel_err,  0);

        // leave manual while in error: outputs rebuilt from held sel
        if6.sel_in = 3'd7;
        tick();
        check("err_again", if6.sel_err, 1);
        if6.mode = 2'b01;
        tick();
        check("leave_sel",    if6.sel_q,    5);
        check("leave_onehot", if6.onehot_q, 32'h20);
        check("leave_data",   if6.data_out, 4'h3);
        check("leave_err",    if6.sel_err,  0);

        // scan down, DWELL=1, wrap 0 -> 5
        if6.mode = 2'b00;
        if6.sel_in = 3'd0;
        tick();
        check("dn_start", if6.sel_q, 0);
        if6.mode = 2'b10;
        tick();
        check("dn_idle_sel", if6.sel_q, 0);
        if6.en = 1'b1;
        tick();
        check("dn_wrap_sel", if6.sel_q, 5);
        check("dn_wrap",     if6.wrap,  1);
        check("dn_wrap_dat", if6.data_out, 4'h3);
        if6.en = 1'b0;
        tick();
        check("dn_wrap_clr", if6.wrap,  0);
        if6.en = 1'b1;
        tick();
        check("dn_step_sel", if6.sel_q, 4);
        check("dn_step_wrap", if6.wrap, 0);
        if6.en = 1'b0;

        // en in manual has no effect beyond the select
        if8.sel_in = 3'd6;
        if8.en = 1'b1;
        tick();
        check("man_en_sel", if8.sel_q, 6);
        check("man_en_wrap", if8.wrap, 0);
        if8.en = 1'b0;

        // scan up, DWELL=4, from 6: step at 4th en, wrap at 8th
        if8.mode = 2'b01;
        tick();
        check("up_enter", if8.sel_q, 6);
        if8.en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("up_sel_%0d", k), if8.sel_q, (k < 4) ? 6 : ((k < 8) ? 7 : 0));
            check($sformatf("up_wrap_%0d", k), if8.wrap, (k == 8) ? 1 : 0);
        end
        if8.en = 1'b0;
        tick();
        check("up_wrap_clr", if8.wrap, 0);
        check("up_data0",    if8.data_out, 4'h1);
        if8.data_in[3:0] = 4'h7;
        tick();
        check("up_track", if8.data_out, 4'h7);

        // freeze mid-dwell
        if8.en = 1'b1;
        tick();
        tick();
        if8.en = 1'b0;
        if8.mode = 2'b11;
        tick();
        if8.data_in[3:0] = 4'hF;
        if8.en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("frz_sel",    if8.sel_q,    0);
        check("frz_onehot", if8.onehot_q, 32'h01);
        check("frz_data",   if8.data_out, 4'h7);
        check("frz_wrap",   if8.wrap,     0);
        if8.en = 1'b0;
        if8.mode = 2'b01;
        tick();
        check("unfrz_data", if8.data_out, 4'hF);
        if8.en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("unfrz_3en", if8.sel_q, 0);
        tick();
        check("unfrz_4en",    if8.sel_q,    1);
        check("unfrz_onehot", if8.onehot_q, 32'h02);
        check("unfrz_data1",  if8.data_out, 4'h2);

        // reset during scan with en high
        tick();
        reset = 1'b1;
        tick();
        check("midrst_sel",    if8.sel_q,    0);
        check("midrst_onehot", if8.onehot_q, 32'h01);
        check("midrst_data",   if8.data_out, 0);
        check("midrst_wrap",   if8.wrap,     0);
        check("midrst6_sel",   if6.sel_q,    0);
        reset = 1'b0;
        if8.en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
